// File: rtl/sccb_target.sv
// SCCB (I2C-like) register-access target: decodes device/register/data bytes from
// raw SIOC/SIOD pads, issues register writes and serves sequential reads.
module sccb_target #(
    parameter logic [7:0] DEVICE_ADDR = 8'h42,
    parameter int         ACK_EN      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, DEV, REG, WDATA, RDATA, IGNORE} state_t;

    state_t      state;
    logic        sioc_p0, sioc_p1, sioc_p2;
    logic        siod_p0, siod_p1, siod_p2;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        ack_pend;

    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  rx_byte;

    // Stage p0/p1: 2-FF synchronizer; p2: one-clk delayed copy for edge decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_p0 <= 1'b1;
            sioc_p1 <= 1'b1;
            sioc_p2 <= 1'b1;
            siod_p0 <= 1'b1;
            siod_p1 <= 1'b1;
            siod_p2 <= 1'b1;
        end else begin
            sioc_p0 <= sioc_i;
            sioc_p1 <= sioc_p0;
            sioc_p2 <= sioc_p1;
            siod_p0 <= siod_i;
            siod_p1 <= siod_p0;
            siod_p2 <= siod_p1;
        end
    end

    // SIOC must be high in both samples, so a SIOD edge coincident with a SIOC edge is data
    assign scl_rise  =  sioc_p1 & ~sioc_p2;
    assign scl_fall  = ~sioc_p1 &  sioc_p2;
    assign start_det =  sioc_p1 &  sioc_p2 & ~siod_p1 &  siod_p2;
    assign stop_det  =  sioc_p1 &  sioc_p2 &  siod_p1 & ~siod_p2;
    assign rx_byte   = {shreg[6:0], siod_p1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            siod_oe  <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            rd_addr  <= 8'h00;
            busy     <= 1'b0;
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            ack_pend <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start_det) begin
                state    <= DEV;
                bit_cnt  <= 4'd0;
                ack_pend <= 1'b0;
                siod_oe  <= 1'b0;
                busy     <= 1'b1;
            end else if (stop_det) begin
                state    <= IDLE;
                bit_cnt  <= 4'd0;
                ack_pend <= 1'b0;
                siod_oe  <= 1'b0;
                busy     <= 1'b0;
            end else if (state != IDLE && state != IGNORE) begin
                if (scl_rise) begin
                    if (bit_cnt != 4'd8) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (state != RDATA)
                            shreg <= rx_byte;
                        // Byte decision is taken on the 8th data bit; the ACK follows in bit 9
                        if (bit_cnt == 4'd7) begin
                            case (state)
                                DEV: begin
                                    if (rx_byte == DEVICE_ADDR) begin
                                        ack_pend <= 1'b1;
                                        state    <= REG;
                                    end else if (rx_byte == (DEVICE_ADDR | 8'h01)) begin
                                        ack_pend <= 1'b1;
                                        state    <= RDATA;
                                    end else begin
                                        ack_pend <= 1'b0;
                                        state    <= IGNORE;
                                    end
                                end
                                REG: begin
                                    rd_addr  <= rx_byte;
                                    ack_pend <= 1'b1;
                                    state    <= WDATA;
                                end
                                WDATA: begin
                                    wr_en    <= 1'b1;
                                    wr_addr  <= rd_addr;
                                    wr_data  <= rx_byte;
                                    rd_addr  <= rd_addr + 8'd1;
                                    ack_pend <= 1'b1;
                                end
                                default: ack_pend <= 1'b0;
                            endcase
                        end
                    end else begin
                        bit_cnt  <= 4'd0;
                        ack_pend <= 1'b0;
                        // 9th bit of a byte we transmitted carries the master's ACK/NA
                        if (state == RDATA && !ack_pend) begin
                            if (!siod_p1)
                                rd_addr <= rd_addr + 8'd1;
                            else
                                state <= IGNORE;
                        end
                    end
                end else if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        siod_oe <= ack_pend && (ACK_EN != 0);
                    end else if (state == RDATA) begin
                        if (bit_cnt == 4'd0) begin
                            siod_oe <= ~rd_data[7];
                            shreg   <= {rd_data[6:0], 1'b0};
                        end else begin
                            siod_oe <= ~shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                        end
                    end else begin
                        siod_oe <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: a bit-banged SCCB master on a wired-AND SIOD line
// plus a small register file model feeding rd_data.
`timescale 1ns/1ps
module tb_sccb_target;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       sioc_i = 1'b1;
    logic       siod_m = 1'b1;
    logic       siod_i;
    logic       siod_oe, wr_en, busy;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

    int         checks   = 0;
    int         failures = 0;
    int         wr_cnt   = 0;
    int         oe_hi    = 0;
    logic [7:0] wr_a [16];
    logic [7:0] wr_d [16];
    time        q = 2500;

    always #20 clk = ~clk;

    assign siod_i  = siod_m & ~siod_oe;
    assign rd_data = (rd_addr == 8'h3A) ? 8'h5C : (rd_addr ^ 8'h66);

    sccb_target #(.DEVICE_ADDR(8'h42), .ACK_EN(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sioc_i  (sioc_i),
        .siod_i  (siod_i),
        .siod_oe (siod_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 16) begin
                wr_a[wr_cnt] = wr_addr;
                wr_d[wr_cnt] = wr_data;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (siod_oe)
            oe_hi = oe_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_x(input logic b, output logic s);
        #(q) siod_m = b;
        #(q) sioc_i = 1'b1;
        #(q) s = siod_i;
        #(q) sioc_i = 1'b0;
    endtask

    // Data changes exactly together with the SIOC edges
    task automatic co_bit(input logic b);
        #(2*q);
        sioc_i = 1'b1;
        siod_m = b;
        #(2*q);
        sioc_i = 1'b0;
        siod_m = ~b;
    endtask

    task automatic start_c();
        #(q) siod_m = 1'b1;
        #(q) sioc_i = 1'b1;
        #(q) siod_m = 1'b0;
        #(q) sioc_i = 1'b0;
    endtask

    task automatic stop_c();
        #(q) siod_m = 1'b0;
        #(q) sioc_i = 1'b1;
        #(q) siod_m = 1'b1;
        #(q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(d[i], s);
        bit_x(1'b1, s);
        ack = ~s;
    endtask

    task automatic co_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) co_bit(d[i]);
        bit_x(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, s);
            d[i] = s;
        end
        bit_x(~mack, s);
    endtask

    initial begin
        logic       a1, a2, a3, a4;
        logic [7:0] d;
        int         base, obase;

        // Reset state
        #113;
        chk("rst_siod_oe", siod_oe, 0);
        chk("rst_wr_en",   wr_en,   0);
        chk("rst_busy",    busy,    0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        #100;

        // 3-phase write at 100 kHz
        base = wr_cnt;
        start_c();
        write_byte(8'h42, a1);
        write_byte(8'h12, a2);
        write_byte(8'h80, a3);
        chk("t1_ack_dev",  a1, 1);
        chk("t1_ack_reg",  a2, 1);
        chk("t1_ack_data", a3, 1);
        chk("t1_busy_mid", busy, 1);
        stop_c();
        chk("t1_wr_count", wr_cnt - base, 1);
        chk("t1_wr_addr",  wr_a[base], 8'h12);
        chk("t1_wr_data",  wr_d[base], 8'h80);
        chk("t1_rd_addr",  rd_addr, 8'h13);
        chk("t1_busy_end", busy, 0);

        q = 1000;

        // Auto-increment wrap from FF to 00
        base = wr_cnt;
        start_c();
        write_byte(8'h42, a1);
        write_byte(8'hFF, a2);
        write_byte(8'h11, a3);
        write_byte(8'h22, a4);
        stop_c();
        chk("t2_acks",     {a1, a2, a3, a4}, 4'hF);
        chk("t2_wr_count", wr_cnt - base, 2);
        chk("t2_wr0_addr", wr_a[base],     8'hFF);
        chk("t2_wr0_data", wr_d[base],     8'h11);
        chk("t2_wr1_addr", wr_a[base + 1], 8'h00);
        chk("t2_wr1_data", wr_d[base + 1], 8'h22);
        chk("t2_rd_addr",  rd_addr, 8'h01);

        // 2-phase write sets the pointer, then a read with master NA
        base = wr_cnt;
        start_c();
        write_byte(8'h42, a1);
        write_byte(8'h3A, a2);
        stop_c();
        chk("t3_ptr_acks", {a1, a2}, 2'b11);
        chk("t3_ptr_rd",   rd_addr, 8'h3A);
        start_c();
        write_byte(8'h43, a1);
        read_byte(1'b0, d);
        stop_c();
        chk("t3_rd_ack",   a1, 1);
        chk("t3_rd_data",  d, 8'h5C);
        chk("t3_rd_addr",  rd_addr, 8'h3A);
        chk("t3_wr_count", wr_cnt - base, 0);

        // Two-byte sequential read: master ACK then NA
        start_c();
        write_byte(8'h43, a1);
        read_byte(1'b1, d);
        chk("t3b_data0", d, 8'h5C);
        read_byte(1'b0, d);
        chk("t3b_data1", d, 8'h5D);
        stop_c();
        chk("t3b_rd_addr", rd_addr, 8'h3B);

        // Foreign device address: never drives, stays busy until STOP
        base  = wr_cnt;
        obase = oe_hi;
        start_c();
        write_byte(8'h60, a1);
        write_byte(8'h12, a2);
        chk("t4_nack",     {a1, a2}, 2'b00);
        chk("t4_busy_mid", busy, 1);
        stop_c();
        chk("t4_oe_cycles", oe_hi - obase, 0);
        chk("t4_wr_count",  wr_cnt - base, 0);
        chk("t4_busy_end",  busy, 0);
        chk("t4_rd_addr",   rd_addr, 8'h3B);

        // STOP after 4 data bits in the write-data phase
        base = wr_cnt;
        start_c();
        write_byte(8'h42, a1);
        write_byte(8'h55, a2);
        bit_x(1'b1, a3);
        bit_x(1'b0, a3);
        bit_x(1'b1, a3);
        bit_x(1'b0, a3);
        stop_c();
        chk("t5_wr_count", wr_cnt - base, 0);
        chk("t5_rd_addr",  rd_addr, 8'h55);
        chk("t5_siod_oe",  siod_oe, 0);
        chk("t5_busy",     busy, 0);
        start_c();
        write_byte(8'h42, a1);
        write_byte(8'h20, a2);
        write_byte(8'h99, a3);
        stop_c();
        chk("t5_next_acks",  {a1, a2, a3}, 3'b111);
        chk("t5_next_count", wr_cnt - base, 1);
        chk("t5_next_addr",  wr_a[base], 8'h20);
        chk("t5_next_data",  wr_d[base], 8'h99);
        chk("t5_next_rd",    rd_addr, 8'h21);

        // Reset pulsed while the target is driving ACK
        base = wr_cnt;
        start_c();
        for (int i = 7; i >= 0; i--) bit_x(d[0] ^ d[0] ^ logic'((8'h42 >> i) & 8'h01), a1);
        for (int i = 0; i < 20 && !siod_oe; i++) @(posedge clk);
        #1;
        chk("t6_ack_driven", siod_oe, 1);
        #4;
        rst_n = 1'b0;
        #1;
        chk("t6_async_release", siod_oe, 0);
        chk("t6_rst_busy",      busy, 0);
        chk("t6_rst_rd_addr",   rd_addr, 0);
        #47;
        rst_n = 1'b1;
        #(q) sioc_i = 1'b1;
        #(2*q) sioc_i = 1'b0;
        write_byte(8'h42, a1);
        chk("t6_no_start_nack", a1, 0);
        chk("t6_no_start_busy", busy, 0);
        stop_c();
        start_c();
        write_byte(8'h42, a1);
        write_byte(8'h07, a2);
        write_byte(8'hAB, a3);
        stop_c();
        chk("t6_next_acks",  {a1, a2, a3}, 3'b111);
        chk("t6_next_count", wr_cnt - base, 1);
        chk("t6_next_addr",  wr_a[base], 8'h07);
        chk("t6_next_data",  wr_d[base], 8'hAB);
        chk("t6_next_rd",    rd_addr, 8'h08);

        // SIOD toggling in the same sample as SIOC edges is plain data
        base = wr_cnt;
        start_c();
        write_byte(8'h42, a1);
        co_byte(8'h5A, a2);
        chk("t7_busy_mid", busy, 1);
        write_byte(8'h3C, a3);
        stop_c();
        chk("t7_acks",     {a1, a2, a3}, 3'b111);
        chk("t7_wr_count", wr_cnt - base, 1);
        chk("t7_wr_addr",  wr_a[base], 8'h5A);
        chk("t7_wr_data",  wr_d[base], 8'h3C);
        chk("t7_rd_addr",  rd_addr, 8'h5B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sccb_target.md
SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 Parameter DEVICE_ADDR, default 8'h42, 8-bit write address; the read address is DEVICE_ADDR|8'h01.
REQ-002 Parameter ACK_EN, default 1; 1 = drive ACK low in each 9th bit of an accepted byte, 0 = never drive during the 9th bit (SCCB don't-care).
REQ-003 clk  in  1  system clock; frequency SHALL be >= 20x the SIOC frequency.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 sioc_i  in  1  raw SIOC pad level, asynchronous.
REQ-006 siod_i  in  1  raw SIOD pad level, asynchronous.
REQ-007 siod_oe  out  1  1 = pull SIOD low (open-drain); 0 = release.
REQ-008 wr_en  out  1  one-clk pulse: register write.
REQ-009 wr_addr  out  8  write register address, valid with wr_en.
REQ-010 wr_data  out  8  write data, valid with wr_en.
REQ-011 rd_addr  out  8  current register pointer.
REQ-012 rd_data  in  8  register contents at rd_addr; combinational from the register file.
REQ-013 busy  out  1  high from a START until the next STOP, or until the transaction is abandoned.

Function
REQ-014 sioc_i and siod_i SHALL each pass through a 2-FF synchronizer; all decoding SHALL use the synchronized values and their 1-clk-delayed copies.
REQ-015 START = synchronized SIOD falls while synchronized SIOC is high in both the current and previous sample. STOP = synchronized SIOD rises under the same SIOC condition.
REQ-016 A SIOD edge coincident with a SIOC edge in the same sample SHALL be treated as data, not as START or STOP.
REQ-017 Bits SHALL be sampled on the synchronized SIOC rising edge and assembled MSB first into an 8-bit shift register; a 4-bit bit counter counts 0..8, and count 8 is the 9th (ACK/NA) bit.
REQ-018 States: IDLE, DEV, REG, WDATA, RDATA, IGNORE. Each byte state is subdivided by the bit counter into 8 data bits and 1 ACK bit.
REQ-019 IDLE: on START go to DEV and clear the bit counter; all other activity is ignored.
REQ-020 DEV, on the 8th bit:
- byte == DEVICE_ADDR: ACK; next state REG.
- byte == DEVICE_ADDR|1: ACK; next state RDATA.
- otherwise: no ACK; next state IGNORE.
REQ-021 REG, on the 8th bit: rd_addr <= byte; ACK; next state WDATA.
REQ-022 WDATA, on the 8th bit:
- wr_addr <= rd_addr, wr_data <= byte, one-clk wr_en pulse.
- rd_addr then increments modulo 256 (8'hFF wraps to 8'h00).
- ACK; remain in WDATA for further bytes.
REQ-023 RDATA:
- Load rd_data into the shift register on entry and after each master ACK.
- Drive siod_oe = ~bit, MSB first; each bit changes 1 clk after a synchronized SIOC falling edge.
- Release SIOD during the 9th bit and sample it: low (ACK) = increment rd_addr and send the next byte; high (NA) = release SIOD and go to IGNORE.
REQ-024 ACK timing (when ACK_EN = 1):
- Assert siod_oe 1 clk after the synchronized SIOC falling edge that ends bit 8.
- Release it 1 clk after the falling edge that ends the 9th bit.
- siod_oe SHALL never change while synchronized SIOC is high.
REQ-025 IGNORE: siod_oe = 0; wait for START or STOP.
REQ-026 STOP in any state: go to IDLE and release siod_oe. A partial byte SHALL be discarded, with no wr_en and no rd_addr change.
REQ-027 START in any non-IDLE state (repeated start): go to DEV and clear the bit counter. rd_addr SHALL be retained.
REQ-028 A 2-phase write (device address + register address, then STOP) sets rd_addr only; wr_en SHALL NOT pulse.
REQ-029 End-to-end latency from a pad SIOC edge to the siod_oe change SHALL be 3-4 clk.

Reset
REQ-030 While rst_n is low: state = IDLE, siod_oe = 0, wr_en = 0, busy = 0, wr_addr = 0, wr_data = 0, rd_addr = 0, bit counter = 0, synchronizers = 1.
REQ-031 Reset asserted mid-transaction SHALL release SIOD immediately (asynchronously).
REQ-032 After rst_n deasserts, the block SHALL ignore bus activity until a fresh START.

Verification
REQ-033 3-phase write, bytes 42/12/80 at 100 kHz with 25 MHz clk -> one wr_en pulse with wr_addr = 12, wr_data = 80; ACK low in three 9th bits; rd_addr = 13; busy drops at STOP.
REQ-034 Write 42/FF/11/22 -> wr_en pulses (FF,11) then (00,22); rd_addr = 01.
REQ-035 Write 42/3A, STOP, then read 43 with rd_data = 5C and master NA -> SIOD carries 5C MSB first; no wr_en pulse; rd_addr = 3A.
REQ-036 Device byte 60 -> siod_oe stays 0 through the whole transaction; no wr_en pulse; busy = 1 until STOP.
REQ-037 STOP after 4 data bits in WDATA, and separately rst_n pulsed low during an ACK bit -> no wr_en pulse; siod_oe = 0 within 1 clk (async in the reset case); the next transaction completes normally.
REQ-038 SIOC and SIOD toggled in the same clk sample -> no START/STOP decoded; the bit is sampled as data.
